// File: rtl/hamming_serializer.sv
// Hamming(7,4) encoder and serializer.
// Captures one data nibble, builds the 7-bit codeword (plus an optional
// overall even-parity bit), and shifts it out LSB-of-send-order first.
// Each bit is held for CLKS_PER_BIT clock cycles.
//
// Upstream handshake: the upstream stage presents nibble_in with
// nibble_valid high. The nibble is taken on the first rising edge where
// nibble_valid=1 and the block is idle. busy rises on that same edge and
// stays high until the last bit period ends. A new rising edge of
// nibble_valid seen while busy is a dropped offer and sets the sticky
// drop_err flag.
module hamming_serializer #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [0:3] nibble_in,
  input  logic       nibble_valid,
  input  logic       ext_parity,
  output logic       busy,
  output logic       tx_bit,
  output logic       tx_valid,
  output logic       frame_start,
  output logic       drop_err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_SEND   = 2'd2
  } state_t;

  localparam logic [3:0] CYC_LAST = 4'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [0:3] data_q, data_d;
  logic       par_en_q, par_en_d;
  logic [7:0] cw_q, cw_d;
  logic [2:0] bit_q, bit_d;
  logic [3:0] cyc_q, cyc_d;
  logic       busy_q, busy_d;
  logic       tx_bit_q, tx_bit_d;
  logic       tx_valid_q, tx_valid_d;
  logic       frame_start_q, frame_start_d;
  logic       drop_q, drop_d;
  logic       nv_prev_q, nv_prev_d;

  logic       p1, p2, p3, p_all;
  logic [7:0] cw_enc;
  logic       cyc_end;
  logic       last_bit;
  logic [2:0] bit_nxt;

  // Codeword from the captured nibble; cw_enc[i] is the i-th bit sent.
  always_comb begin
    p1     = data_q[0] ^ data_q[1] ^ data_q[3];
    p2     = data_q[0] ^ data_q[2] ^ data_q[3];
    p3     = data_q[1] ^ data_q[2] ^ data_q[3];
    p_all  = p1 ^ p2 ^ data_q[0] ^ p3 ^ data_q[1] ^ data_q[2] ^ data_q[3];
    cw_enc = {par_en_q & p_all, data_q[3], data_q[2], data_q[1],
              p3, data_q[0], p2, p1};
  end

  // Bit-period and end-of-frame detection.
  always_comb begin
    cyc_end  = (cyc_q == CYC_LAST);
    last_bit = (bit_q == (par_en_q ? 3'd7 : 3'd6));
    bit_nxt  = bit_q + 3'd1;
  end

  // State register plus all datapath/output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      data_q        <= '0;
      par_en_q      <= 1'b0;
      cw_q          <= '0;
      bit_q         <= '0;
      cyc_q         <= '0;
      busy_q        <= 1'b0;
      tx_bit_q      <= 1'b0;
      tx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      drop_q        <= 1'b0;
      nv_prev_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      par_en_q      <= par_en_d;
      cw_q          <= cw_d;
      bit_q         <= bit_d;
      cyc_q         <= cyc_d;
      busy_q        <= busy_d;
      tx_bit_q      <= tx_bit_d;
      tx_valid_q    <= tx_valid_d;
      frame_start_q <= frame_start_d;
      drop_q        <= drop_d;
      nv_prev_q     <= nv_prev_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (nibble_valid) state_d = S_ENCODE;
      S_ENCODE: state_d = S_SEND;
      S_SEND:   if (cyc_end && last_bit) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values for each state.
  always_comb begin
    data_d        = data_q;
    par_en_d      = par_en_q;
    cw_d          = cw_q;
    bit_d         = bit_q;
    cyc_d         = cyc_q;
    busy_d        = busy_q;
    tx_bit_d      = tx_bit_q;
    tx_valid_d    = tx_valid_q;
    frame_start_d = frame_start_q;
    // A fresh rising edge of the strobe while busy is a lost offer.
    nv_prev_d     = nibble_valid;
    drop_d        = drop_q | (nibble_valid & ~nv_prev_q & busy_q);
    case (state_q)
      S_IDLE: begin
        if (nibble_valid) begin
          data_d   = nibble_in;
          par_en_d = ext_parity;
          busy_d   = 1'b1;
        end
      end
      S_ENCODE: begin
        cw_d          = cw_enc;
        tx_bit_d      = cw_enc[0];
        tx_valid_d    = 1'b1;
        frame_start_d = 1'b1;
        bit_d         = 3'd0;
        cyc_d         = 4'd0;
      end
      S_SEND: begin
        frame_start_d = 1'b0;
        if (cyc_end) begin
          cyc_d = 4'd0;
          if (last_bit) begin
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            tx_bit_d   = 1'b0;
          end else begin
            bit_d    = bit_nxt;
            tx_bit_d = cw_q[bit_nxt];
          end
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign busy        = busy_q;
  assign tx_bit      = tx_bit_q;
  assign tx_valid    = tx_valid_q;
  assign frame_start = frame_start_q;
  assign drop_err    = drop_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_hamming_serializer.sv
// Bench for hamming_serializer: one instance with CLKS_PER_BIT=2 and one
// with CLKS_PER_BIT=1 share the same stimulus; sel_b picks which one is
// observed. Expected frames come from a positional Hamming(7,4) model.
module tb_hamming_serializer;

  logic       clk;
  logic       reset;
  logic [0:3] nibble_in;
  logic       nibble_valid;
  logic       ext_parity;

  logic busy_a, tx_bit_a, tx_valid_a, frame_start_a, drop_err_a;
  logic busy_b, tx_bit_b, tx_valid_b, frame_start_b, drop_err_b;
  logic [1:0] state_dbg_a, state_dbg_b;

  logic sel_b;
  logic o_busy, o_tx_bit, o_tx_valid, o_frame_start, o_drop_err;
  logic [1:0] o_state;

  int total;
  int bad;
  logic exp_drop;
  logic [0:0] exp_q[$];

  hamming_serializer #(.CLKS_PER_BIT(2)) dut_a (
    .clk(clk), .reset(reset), .nibble_in(nibble_in),
    .nibble_valid(nibble_valid), .ext_parity(ext_parity),
    .busy(busy_a), .tx_bit(tx_bit_a), .tx_valid(tx_valid_a),
    .frame_start(frame_start_a), .drop_err(drop_err_a),
    .state_dbg(state_dbg_a)
  );

  hamming_serializer #(.CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .reset(reset), .nibble_in(nibble_in),
    .nibble_valid(nibble_valid), .ext_parity(ext_parity),
    .busy(busy_b), .tx_bit(tx_bit_b), .tx_valid(tx_valid_b),
    .frame_start(frame_start_b), .drop_err(drop_err_b),
    .state_dbg(state_dbg_b)
  );

  assign o_busy        = sel_b ? busy_b        : busy_a;
  assign o_tx_bit      = sel_b ? tx_bit_b      : tx_bit_a;
  assign o_tx_valid    = sel_b ? tx_valid_b    : tx_valid_a;
  assign o_frame_start = sel_b ? frame_start_b : frame_start_a;
  assign o_drop_err    = sel_b ? drop_err_b    : drop_err_a;
  assign o_state       = sel_b ? state_dbg_b   : state_dbg_a;

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hamming(7,4) by codeword position: data sits at positions 3,5,6,7,
  // parity bit k (position 2^k) covers every position with bit k set.
  // Frame bit i is position i+1; bit 7 is the overall parity.
  function automatic void model(input logic [0:3] nib, input logic par,
                                output logic [7:0] bits, output int n);
    logic [7:0] pos;
    logic p;
    pos    = '0;
    pos[3] = nib[0];
    pos[5] = nib[1];
    pos[6] = nib[2];
    pos[7] = nib[3];
    for (int k = 0; k < 3; k++) begin
      p = 1'b0;
      for (int j = 1; j <= 7; j++)
        if (((j >> k) & 1) == 1) p = p ^ pos[j];
      pos[1 << k] = p;
    end
    bits = '0;
    for (int i = 0; i < 7; i++) bits[i] = pos[i+1];
    bits[7] = par ? ^pos : 1'b0;
    n = par ? 8 : 7;
  endfunction

  // Offer one nibble at the current negedge and follow the whole frame.
  // inject_idx: cycle (0 = encode cycle) at which a second offer is made.
  // abort_idx: cycle at which reset is asserted mid-frame.
  task automatic run_frame(input logic [0:3] nib, input logic par,
                           input int inject_idx, input int abort_idx);
    logic [7:0] bits;
    int n;
    int c;
    logic [0:0] e;
    c = sel_b ? 1 : 2;
    model(nib, par, bits, n);
    exp_q.delete();
    for (int i = 0; i < n; i++)
      for (int r = 0; r < c; r++) exp_q.push_back(bits[i]);
    nibble_in    = nib;
    ext_parity   = par;
    nibble_valid = 1'b1;
    @(negedge clk);
    nibble_valid = 1'b0;
    nibble_in    = 4'($urandom);
    ext_parity   = 1'($urandom);
    for (int idx = 0; idx < 1 + n * c; idx++) begin
      if (idx != 0) @(negedge clk);
      chk("busy_in_frame", {7'd0, o_busy}, 8'd1);
      if (idx == 0) begin
        chk("encode_tx_valid", {7'd0, o_tx_valid}, 8'd0);
        chk("encode_frame_start", {7'd0, o_frame_start}, 8'd0);
      end else begin
        e = exp_q.pop_front();
        chk("tx_valid", {7'd0, o_tx_valid}, 8'd1);
        chk("tx_bit", {7'd0, o_tx_bit}, {7'd0, e});
        chk("frame_start", {7'd0, o_frame_start}, (idx == 1) ? 8'd1 : 8'd0);
      end
      if (idx == inject_idx) begin
        nibble_valid = 1'b1;
        nibble_in    = 4'($urandom);
        exp_drop     = 1'b1;
      end
      if (idx == inject_idx + 1) nibble_valid = 1'b0;
      if (idx == abort_idx) begin
        reset = 1'b1;
        #1;
        chk("abort_busy", {7'd0, o_busy}, 8'd0);
        chk("abort_tx_valid", {7'd0, o_tx_valid}, 8'd0);
        chk("abort_tx_bit", {7'd0, o_tx_bit}, 8'd0);
        chk("abort_frame_start", {7'd0, o_frame_start}, 8'd0);
        chk("abort_drop_err", {7'd0, o_drop_err}, 8'd0);
        chk("abort_state", {6'd0, o_state}, 8'd0);
        nibble_valid = 1'b1;
        @(negedge clk);
        chk("reset_ignores_valid", {7'd0, o_busy}, 8'd0);
        nibble_valid = 1'b0;
        reset    = 1'b0;
        exp_drop = 1'b0;
        @(negedge clk);
        chk("after_abort_tx_valid", {7'd0, o_tx_valid}, 8'd0);
        return;
      end
    end
    @(negedge clk);
    chk("busy_fall", {7'd0, o_busy}, 8'd0);
    chk("end_tx_valid", {7'd0, o_tx_valid}, 8'd0);
    chk("end_tx_bit", {7'd0, o_tx_bit}, 8'd0);
    chk("end_frame_start", {7'd0, o_frame_start}, 8'd0);
    chk("drop_err", {7'd0, o_drop_err}, {7'd0, exp_drop});
    chk("end_state_idle", {6'd0, o_state}, 8'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    exp_drop = 1'b0;
    @(negedge clk);
  endtask

  // Directed and random sequence
  initial begin
    total        = 0;
    bad          = 0;
    exp_drop     = 1'b0;
    sel_b        = 1'b0;
    reset        = 1'b1;
    nibble_in    = '0;
    nibble_valid = 1'b0;
    ext_parity   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {7'd0, o_busy}, 8'd0);
    chk("reset_tx_valid", {7'd0, o_tx_valid}, 8'd0);
    chk("reset_tx_bit", {7'd0, o_tx_bit}, 8'd0);
    chk("reset_frame_start", {7'd0, o_frame_start}, 8'd0);
    chk("reset_drop_err", {7'd0, o_drop_err}, 8'd0);
    chk("reset_state", {6'd0, o_state}, 8'd0);
    reset = 1'b0;
    @(negedge clk);

    // 7-bit frame, 2 cycles per bit: 0,1,1,0,0,1,1
    run_frame(4'b1011, 1'b0, -10, -10);
    // 8-bit frames: all ones with P=1, then all zeros
    run_frame(4'b1111, 1'b1, -10, -10);
    run_frame(4'b0000, 1'b1, -10, -10);
    // Back-to-back byte 0xB4: 1011 then 0100, no gap
    run_frame(4'b1011, 1'b0, -10, -10);
    run_frame(4'b0100, 1'b0, -10, -10);
    // Second offer 4 cycles in; frame unchanged, drop_err set and held
    run_frame(4'b0110, 1'b1, 4, -10);
    // Offered in the first idle cycle after busy fell
    run_frame(4'b1001, 1'b0, -10, -10);
    // Reset at bit 3 (2 cycles per bit), then a complete frame
    run_frame(4'b1101, 1'b1, -10, 1 + 3 * 2);
    run_frame(4'b0011, 1'b1, -10, -10);

    // CLKS_PER_BIT = 1 instance
    sel_b = 1'b1;
    pulse_reset();
    run_frame(4'b1000, 1'b1, -10, -10);
    run_frame(4'b0101, 1'b0, -10, 1 + 3);
    for (int i = 0; i < 6; i++)
      run_frame(4'($urandom), 1'($urandom_range(1, 0)), -10, -10);

    // Random frames on the CLKS_PER_BIT = 2 instance
    sel_b = 1'b0;
    pulse_reset();
    for (int i = 0; i < 6; i++)
      run_frame(4'($urandom), 1'($urandom_range(1, 0)), -10, -10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
